// File: rtl/glb_crd_rd_port.sv
// Coordinate read port of the global buffer: accepts word addresses from CTR,
// reads a 1-cycle-latency SRAM and returns words in order through a credit-protected FIFO.
module glb_crd_rd_port #(
  parameter int SRAM_WIDTH = 256,
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  CCUGLB_Rst,
  input  logic [ADDR_WIDTH-1:0] CCUGLB_CfgBase,
  input  logic [ADDR_WIDTH-1:0] CTRGLB_CrdAddr,
  input  logic                  CTRGLB_CrdAddrVld,
  output logic                  GLBCTR_CrdAddrRdy,
  output logic [SRAM_WIDTH-1:0] GLBCTR_Crd,
  output logic                  GLBCTR_CrdVld,
  input  logic                  CTRGLB_CrdRdy,
  output logic                  GLBSRAM_RdEn,
  output logic [ADDR_WIDTH-1:0] GLBSRAM_Addr,
  input  logic [SRAM_WIDTH-1:0] SRAMGLB_RdData,
  output logic                  GLBCCU_Idle
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [SRAM_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [SRAM_WIDTH-1:0] crdHead;
  logic [PTR_W-1:0]      rdPtr;
  logic [PTR_W-1:0]      wrPtr;
  logic [PTR_W-1:0]      rdPtrNext;
  logic [CNT_W-1:0]      fifoCnt;
  logic [CNT_W-1:0]      creditUsed;
  logic                  inflight;
  logic                  flush;
  logic                  push;
  logic                  pop;

  assign flush      = rst | CCUGLB_Rst;
  assign push       = inflight;
  assign pop        = GLBCTR_CrdVld & CTRGLB_CrdRdy;
  assign rdPtrNext  = rdPtr + PTR_W'(1);

  // Credit counts words already queued plus the one read that may still be in flight.
  assign creditUsed        = fifoCnt + CNT_W'(inflight);
  assign GLBCTR_CrdAddrRdy = (creditUsed < CNT_W'(FIFO_DEPTH)) & ~flush;

  assign GLBSRAM_RdEn  = CTRGLB_CrdAddrVld & GLBCTR_CrdAddrRdy;
  assign GLBSRAM_Addr  = CCUGLB_CfgBase + CTRGLB_CrdAddr;

  assign GLBCTR_CrdVld = (fifoCnt != '0);
  assign GLBCTR_Crd    = crdHead;
  assign GLBCCU_Idle   = (fifoCnt == '0) & ~inflight;

  // NOTE: the storage array has no reset; validity is tracked by the pointers and count,
  // so clearing it would only add reset fan-out to a wide register file.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wrPtr] <= SRAMGLB_RdData;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      fifoCnt  <= '0;
      inflight <= 1'b0;
      crdHead  <= '0;
    end else begin
      inflight <= GLBSRAM_RdEn;
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtrNext;
      fifoCnt <= fifoCnt + CNT_W'(push) - CNT_W'(pop);

      // The head register tracks the entry at rdPtr after this edge; when the FIFO
      // drains it keeps the last popped word.
      if (push && (fifoCnt == '0 || (pop && fifoCnt == CNT_W'(1))))
        crdHead <= SRAMGLB_RdData;
      else if (pop && fifoCnt > CNT_W'(1))
        crdHead <= mem[rdPtrNext];
    end
  end

endmodule

// File: tb/tb_glb_crd_rd_port.sv
// Self-checking bench for glb_crd_rd_port: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue-based reference model.
module tb_glb_crd_rd_port;

  localparam int SW = 256;
  localparam int AW = 10;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          CCUGLB_Rst;
  logic [AW-1:0] CCUGLB_CfgBase;
  logic [AW-1:0] CTRGLB_CrdAddr;
  logic          CTRGLB_CrdAddrVld;
  logic          GLBCTR_CrdAddrRdy;
  logic [SW-1:0] GLBCTR_Crd;
  logic          GLBCTR_CrdVld;
  logic          CTRGLB_CrdRdy;
  logic          GLBSRAM_RdEn;
  logic [AW-1:0] GLBSRAM_Addr;
  logic [SW-1:0] SRAMGLB_RdData;
  logic          GLBCCU_Idle;

  glb_crd_rd_port #(.SRAM_WIDTH(SW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .CCUGLB_Rst        (CCUGLB_Rst),
    .CCUGLB_CfgBase    (CCUGLB_CfgBase),
    .CTRGLB_CrdAddr    (CTRGLB_CrdAddr),
    .CTRGLB_CrdAddrVld (CTRGLB_CrdAddrVld),
    .GLBCTR_CrdAddrRdy (GLBCTR_CrdAddrRdy),
    .GLBCTR_Crd        (GLBCTR_Crd),
    .GLBCTR_CrdVld     (GLBCTR_CrdVld),
    .CTRGLB_CrdRdy     (CTRGLB_CrdRdy),
    .GLBSRAM_RdEn      (GLBSRAM_RdEn),
    .GLBSRAM_Addr      (GLBSRAM_Addr),
    .SRAMGLB_RdData    (SRAMGLB_RdData),
    .GLBCCU_Idle       (GLBCCU_Idle)
  );

  always #5 clk = ~clk;

  // SRAM contents are a fixed function of the address; 0x015 holds the A5 pattern.
  function automatic logic [SW-1:0] sramWord(input logic [AW-1:0] a);
    logic [SW-1:0] w;
    if (a == 10'h015) return {32{8'hA5}};
    for (int i = 0; i < 8; i++)
      w[i*32 +: 32] = ({22'd0, a} * 32'h9E3779B1) ^ (32'(i) << 24) ^ 32'h5A5A_0000;
    return w;
  endfunction

  // 1-cycle SRAM; returns garbage when not enabled so stray captures are visible.
  always @(posedge clk)
    SRAMGLB_RdData <= GLBSRAM_RdEn ? sramWord(GLBSRAM_Addr) : {8{32'($urandom)}};

  typedef struct {
    logic [SW-1:0] data;
    int            visCyc;
  } ent_t;

  ent_t          q[$];
  logic [SW-1:0] lastCrd;
  int            cyc;
  int            total;
  int            bad;
  logic          dutAcc;
  logic          dutPop;

  task automatic check(input string name, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare all outputs against the model, advance the model.
  task automatic step(input logic v, input logic [AW-1:0] a, input logic [AW-1:0] b,
                      input logic cr, input logic sr, input logic r);
    logic          expRdy;
    logic          expEn;
    logic          expVld;
    logic [SW-1:0] expCrd;
    logic [AW-1:0] expAddr;
    @(posedge clk);
    cyc++;
    #1;
    CTRGLB_CrdAddrVld = v;
    CTRGLB_CrdAddr    = a;
    CCUGLB_CfgBase    = b;
    CTRGLB_CrdRdy     = cr;
    CCUGLB_Rst        = sr;
    rst               = r;
    @(negedge clk);
    expRdy  = (q.size() < DEPTH) && !r && !sr;
    expEn   = v && expRdy;
    expVld  = (q.size() > 0) && (q[0].visCyc <= cyc);
    expCrd  = expVld ? q[0].data : lastCrd;
    expAddr = a + b;
    check("addr_rdy", 256'(GLBCTR_CrdAddrRdy), 256'(expRdy));
    check("rd_en",    256'(GLBSRAM_RdEn),      256'(expEn));
    check("rd_addr",  256'(GLBSRAM_Addr),      256'(expAddr));
    check("crd_vld",  256'(GLBCTR_CrdVld),     256'(expVld));
    check("crd_data", GLBCTR_Crd,              expCrd);
    check("idle",     256'(GLBCCU_Idle),       256'(q.size() == 0));
    dutAcc = CTRGLB_CrdAddrVld & GLBCTR_CrdAddrRdy;
    dutPop = GLBCTR_CrdVld & CTRGLB_CrdRdy;
    if (r || sr) begin
      q.delete();
      lastCrd = '0;
    end else begin
      if (expVld && cr) begin
        lastCrd = q[0].data;
        void'(q.pop_front());
      end
      if (expEn) q.push_back('{sramWord(expAddr), cyc + 2});
    end
  endtask

  task automatic idleSteps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int accCnt;
    int popCnt;
    int popAt2;
    int firstPop;
    logic          rv;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    total = 0; bad = 0; cyc = 0; lastCrd = '0;
    dutAcc = 1'b0; dutPop = 1'b0;
    rst = 1'b1; CCUGLB_Rst = 1'b0; CCUGLB_CfgBase = '0; CTRGLB_CrdAddr = '0;
    CTRGLB_CrdAddrVld = 1'b0; CTRGLB_CrdRdy = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state held one more cycle under rst.
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("reset_idle", 256'(GLBCCU_Idle), 256'(1));
    check("reset_rdy_low", 256'(GLBCTR_CrdAddrRdy), 256'(0));

    // Single read: base 0x010 + offset 0x005.
    step(1'b1, 10'h005, 10'h010, 1'b1, 1'b0, 1'b0);
    check("single_en", 256'(GLBSRAM_RdEn), 256'(1));
    check("single_addr", 256'(GLBSRAM_Addr), 256'(10'h015));
    step(1'b0, '0, 10'h010, 1'b1, 1'b0, 1'b0);
    check("single_vld_c1", 256'(GLBCTR_CrdVld), 256'(0));
    step(1'b0, '0, 10'h010, 1'b1, 1'b0, 1'b0);
    check("single_vld_c2", 256'(GLBCTR_CrdVld), 256'(1));
    check("single_data", GLBCTR_Crd, {32{8'hA5}});
    step(1'b0, '0, 10'h010, 1'b1, 1'b0, 1'b0);
    check("single_idle", 256'(GLBCCU_Idle), 256'(1));

    // Streaming 16 words with an always-ready consumer.
    accCnt = 0; popCnt = 0; popAt2 = 0; firstPop = -1;
    for (int i = 0; i < 20; i++) begin
      step(i < 16, 10'(i), '0, 1'b1, 1'b0, 1'b0);
      if (i < 16 && !GLBCTR_CrdAddrRdy) accCnt++;
      if (dutPop) begin
        popCnt++;
        if (firstPop < 0) firstPop = i;
      end
    end
    check("stream_rdy_drops", 256'(accCnt), 256'(0));
    check("stream_pops", 256'(popCnt), 256'(16));
    check("stream_first_pop", 256'(firstPop), 256'(2));

    // Backpressure: exactly FIFO_DEPTH requests accepted while the consumer stalls.
    accCnt = 0;
    for (int i = 0; i < 14; i++) begin
      step(i < 10, 10'(8'h20 + i), '0, i >= 10, 1'b0, 1'b0);
      if (dutAcc) accCnt++;
      if (i == 4)  check("bp_rdy_c4", 256'(GLBCTR_CrdAddrRdy), 256'(0));
      if (i == 10) check("bp_rdy_c10", 256'(GLBCTR_CrdAddrRdy), 256'(0));
      if (i == 11) check("bp_rdy_c11", 256'(GLBCTR_CrdAddrRdy), 256'(1));
    end
    check("bp_accepted", 256'(accCnt), 256'(4));
    idleSteps(4);

    // Address wrap.
    step(1'b1, 10'h002, 10'h3FF, 1'b1, 1'b0, 1'b0);
    check("wrap_addr", 256'(GLBSRAM_Addr), 256'(10'h001));
    idleSteps(4);

    // Soft flush while a read is in flight.
    step(1'b1, 10'h007, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 10'h008, '0, 1'b1, 1'b1, 1'b0);
    check("flush_rdy_c1", 256'(GLBCTR_CrdAddrRdy), 256'(0));
    popCnt = 0;
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    check("flush_rdy_c2", 256'(GLBCTR_CrdAddrRdy), 256'(1));
    check("flush_idle_c2", 256'(GLBCCU_Idle), 256'(1));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      if (GLBCTR_CrdVld) popCnt++;
    end
    check("flush_no_vld", 256'(popCnt), 256'(0));

    // Hard reset with three entries queued, then a fresh single read.
    for (int i = 0; i < 5; i++) step(i < 3, 10'(8'h40 + i), '0, 1'b0, 1'b0, 1'b0);
    check("rq_three_queued", 256'(q.size()), 256'(3));
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    check("rq_vld", 256'(GLBCTR_CrdVld), 256'(0));
    check("rq_idle", 256'(GLBCCU_Idle), 256'(1));
    check("rq_crd", GLBCTR_Crd, 256'(0));
    step(1'b1, 10'h005, 10'h010, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    check("rq_single_data", GLBCTR_Crd, {32{8'hA5}});
    idleSteps(2);

    // Randomized traffic; the producer holds a request stable until accepted.
    rv = 1'b0; ra = '0; rb = '0;
    for (int i = 0; i < 2500; i++) begin
      logic sr;
      logic r;
      if (!rv || dutAcc) begin
        rv = ($urandom_range(9, 0) < 7);
        ra = AW'($urandom);
      end
      if ($urandom_range(49, 0) == 0) rb = AW'($urandom);
      sr = ($urandom_range(59, 0) == 0);
      r  = ($urandom_range(149, 0) == 0);
      step(rv, ra, rb, $urandom_range(9, 0) < 6, sr, r);
      if (sr || r) rv = 1'b0;
    end
    idleSteps(6);
    check("final_idle", 256'(GLBCCU_Idle), 256'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
